// File: rtl/fp27_pkg.sv
// Shared widths, types and helpers for the 27-bit grav_sim float.
// FP_ADD_ROUND_EN selects round-to-nearest-even; default is truncate.
package fp27_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 18;
  localparam int BIAS  = 127;
  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 4;
  localparam int EW    = EXP_W + 2;
  localparam int LZ_W  = $clog2(SIG_W + 1);
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [EXP_W-1:0] EXP_ALL1  = '1;
  localparam logic [EXP_W-1:0] SHIFT_MAX = EXP_W'(MAN_W + 3);
  localparam logic [EW-1:0]    EXP_TOP   = EW'(EXP_MAX);

`ifdef FP_ADD_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp27_t;

  localparam fp27_t FP27_ZERO = 27'h0000000;
  localparam fp27_t FP27_INF  = 27'h3FC0000;
  localparam fp27_t FP27_QNAN = 27'h3FE0000;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  typedef struct packed {
    logic             special;
    fp27_t            spec_val;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic             sub;
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;
  } s1_t;

  typedef struct packed {
    logic             special;
    fp27_t            spec_val;
    logic             sign;
    logic             zero;
    logic [EW-1:0]    exp;
    logic [SIG_W-1:0] norm;
  } s2_t;

  function automatic fp_class_e classify(input fp27_t x);
    if (x.exp == '0) return ZERO;
    if (x.exp != EXP_ALL1) return NORM;
    return (x.man == '0) ? INF : NAN;
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for the normalise step.
module fp_lzc
  import fp27_pkg::*;
#(
  parameter int W = SIG_W
) (
  input  logic [W-1:0]    vec,
  output logic [LZ_W-1:0] cnt
);
  always_comb begin
    cnt = LZ_W'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) cnt = LZ_W'(W - 1 - i);
    end
  end
endmodule

// File: rtl/fp_add27.sv
// Three-stage 27-bit float adder: align, add/normalise, round/pack.
// FP_ADD_ROUND_EN enables RNE rounding; otherwise results truncate.
module fp_add27
  import fp27_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [FP_W-1:0] in1,
  input  logic [FP_W-1:0] in2,
  output logic [FP_W-1:0] sum
);
  fp27_t a, b, big, sml;
  fp_class_e ca, cb;
  logic swap, sticky;
  logic [EXP_W-1:0] d;
  logic [SIG_W-1:0] ext, aligned;
  s1_t s1_n, s1;

  assign a = in1;
  assign b = in2;

  always_comb begin
    ca = classify(a);
    cb = classify(b);
    swap = a[FP_W-2:0] < b[FP_W-2:0];
    big = swap ? b : a;
    sml = swap ? a : b;
    d = big.exp - sml.exp;
    ext = {1'b1, sml.man, 3'b000};
    sticky = 1'b0;
    if (d >= SHIFT_MAX) begin
      aligned = {{(SIG_W-1){1'b0}}, 1'b1};
    end else begin
      aligned = ext >> d[LZ_W-1:0];
      sticky = |(ext & ~({SIG_W{1'b1}} << d[LZ_W-1:0]));
      aligned[0] = aligned[0] | sticky;
    end
    s1_n.special  = 1'b1;
    s1_n.spec_val = FP27_ZERO;
    s1_n.sign     = big.sign;
    s1_n.exp      = big.exp;
    s1_n.sub      = a.sign ^ b.sign;
    s1_n.sig_a    = {1'b1, big.man, 3'b000};
    s1_n.sig_b    = aligned;
    if (ca == NAN || cb == NAN ||
        (ca == INF && cb == INF && a.sign != b.sign))
      s1_n.spec_val = FP27_QNAN;
    else if (ca == INF)
      s1_n.spec_val = a;
    else if (cb == INF)
      s1_n.spec_val = b;
    else if (ca == ZERO && cb == ZERO)
      s1_n.spec_val = {a.sign & b.sign, {(FP_W-1){1'b0}}};
    else if (ca == ZERO)
      s1_n.spec_val = b;
    else if (cb == ZERO)
      s1_n.spec_val = a;
    else
      s1_n.special = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s1 <= '0;
    else      s1 <= s1_n;
  end

  logic [SIG_W:0]   wide;
  logic [LZ_W-1:0]  lz;
  s2_t s2_n, s2;

  fp_lzc #(.W(SIG_W)) u_lzc (
    .vec (wide[SIG_W-1:0]),
    .cnt (lz)
  );

  always_comb begin
    if (s1.sub) wide = {1'b0, s1.sig_a} - {1'b0, s1.sig_b};
    else        wide = {1'b0, s1.sig_a} + {1'b0, s1.sig_b};
    s2_n.special  = s1.special;
    s2_n.spec_val = s1.spec_val;
    s2_n.sign     = s1.sign;
    s2_n.zero     = wide == '0;
    if (wide[SIG_W]) begin
      s2_n.norm = {wide[SIG_W:2], |wide[1:0]};
      s2_n.exp  = {2'b00, s1.exp} + EW'(1);
    end else begin
      s2_n.norm = wide[SIG_W-1:0] << lz;
      s2_n.exp  = {2'b00, s1.exp} - EW'(lz);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s2 <= '0;
    else      s2 <= s2_n;
  end

  logic             up;
  logic [MAN_W+1:0] mant;
  logic [MAN_W-1:0] man;
  logic [EW-1:0]    e3;
  fp27_t            res;

  always_comb begin
    up = ROUND_EN & s2.norm[2]
       & (s2.norm[1] | s2.norm[0] | s2.norm[3]);
    mant = {1'b0, s2.norm[SIG_W-1:3]} + (MAN_W+2)'(up);
    man  = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
    e3   = s2.exp + EW'(mant[MAN_W+1]);
    if (s2.special)
      res = s2.spec_val;
    else if (s2.zero)
      res = FP27_ZERO;
    else if (e3[EW-1] || e3 == '0)
      res = {s2.sign, {(FP_W-1){1'b0}}};
    else if (e3 >= EXP_TOP)
      res = {s2.sign, FP27_INF[FP_W-2:0]};
    else
      res = {s2.sign, e3[EXP_W-1:0], man};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum <= '0;
    else      sum <= res;
  end
endmodule

// File: tb/tb_fp_add27.sv
// Random and directed bench for fp_add27 against an exact-arithmetic model.
// Define FP_ADD_ROUND_EN on both bench and RTL to test the rounding build.
module tb_fp_add27;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [26:0] in1 = '0;
  logic [26:0] in2 = '0;
  logic [26:0] sum;

  int vectors = 0;
  int miscompares = 0;
  logic [26:0] expq[$];
  string       tagq[$];

  fp_add27 dut (
    .clk (clk),
    .rst (rst),
    .in1 (in1),
    .in2 (in2),
    .sum (sum)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [26:0] got,
                          input logic [26:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: sum=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [26:0] ref_add(input logic [26:0] x,
                                          input logic [26:0] y);
    logic [26:0] t;
    logic sa, sb;
    int ea, eb, d, p, sh, e;
    longint unsigned ma, mb, A, B, R, q, rem, half;
    bit nx, ny, ix, iy, zx, zy;
    nx = x[25:18] == 8'hFF && x[17:0] != 0;
    ny = y[25:18] == 8'hFF && y[17:0] != 0;
    ix = x[25:18] == 8'hFF && x[17:0] == 0;
    iy = y[25:18] == 8'hFF && y[17:0] == 0;
    zx = x[25:18] == 0;
    zy = y[25:18] == 0;
    if (nx || ny || (ix && iy && x[26] != y[26])) return 27'h3FE0000;
    if (ix) return x;
    if (iy) return y;
    if (zx && zy) return {x[26] & y[26], 26'h0};
    if (zx) return y;
    if (zy) return x;
    if (x[25:0] < y[25:0]) begin
      t = x; x = y; y = t;
    end
    sa = x[26]; sb = y[26];
    ea = int'(x[25:18]); eb = int'(y[25:18]);
    ma = 64'(x[17:0]); mb = 64'(y[17:0]);
    d = ea - eb;
    A = ((64'd1 << 18) + ma) << 26;
    B = (d <= 26) ? (((64'd1 << 18) + mb) << (26 - d)) : 64'd1;
    R = (sa == sb) ? A + B : A - B;
    if (R == 0) return 27'h0;
    p = 63;
    while (R[p] == 1'b0) p--;
    e = ea + p - 44;
    if (p >= 18) begin
      sh = p - 18;
      q = R >> sh;
`ifdef FP_ADD_ROUND_EN
      if (sh > 0) begin
        rem = R & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q[19]) begin
          q = q >> 1;
          e++;
        end
      end
`else
      rem = 0; half = 0;
`endif
    end else begin
      q = R << (18 - p);
    end
    if (e >= 255) return {sa, 8'hFF, 18'h0};
    if (e <= 0) return {sa, 26'h0};
    return {sa, 8'(e), q[17:0]};
  endfunction

  function automatic logic [26:0] rnd_op();
    logic       s;
    logic [17:0] m;
    s = 1'($urandom);
    m = 18'($urandom);
    case ($urandom_range(0, 31))
      0: return {s, 8'h00, m};
      1: return {s, 8'hFF, 18'h0};
      2: return {s, 8'hFF, m | 18'h1};
      3: return {s, 8'hFE, m};
      4: return {s, 8'h01, m};
      default: return {s, 8'($urandom_range(1, 254)), m};
    endcase
  endfunction

  function automatic logic [26:0] near(input logic [26:0] x);
    int e;
    logic [26:0] y;
    e = int'(x[25:18]) + int'($urandom_range(0, 50)) - 25;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    y = {1'($urandom), 8'(e), 18'($urandom)};
    if ($urandom_range(0, 3) == 0) y[17:0] = x[17:0] ^ 18'($urandom_range(0, 3));
    return y;
  endfunction

  task automatic apply(input string tag, input logic [26:0] x,
                       input logic [26:0] y, input logic [26:0] want);
    @(negedge clk);
    if (expq.size() == 3) check_eq(tagq.pop_front(), sum, expq.pop_front());
    in1 = x;
    in2 = y;
    expq.push_back(want);
    tagq.push_back(tag);
  endtask

  localparam logic [26:0] T5B_EXP =
`ifdef FP_ADD_ROUND_EN
    27'h1FC0002;
`else
    27'h1FC0001;
`endif

  task automatic directed();
    apply("t1_one_plus_one", 27'h1FC0000, 27'h1FC0000, 27'h2000000);
    apply("t2_1p5_plus_0p5", 27'h1FE0000, 27'h1F80000, 27'h2000000);
    apply("t3_cancel",       27'h1FC0000, 27'h5FC0000, 27'h0000000);
    apply("t4_overflow",     27'h3FBFFFF, 27'h3FBFFFF, 27'h3FC0000);
    apply("t4_inf_minus",    27'h3FC0000, 27'h7FC0000, 27'h3FE0000);
    apply("t5_tie_even",     27'h1FC0000, 27'h1B00000, 27'h1FC0000);
    apply("t5_tie_odd",      27'h1FC0001, 27'h1B00000, T5B_EXP);
    apply("inf_plus_fin",    27'h7FC0000, 27'h1FC0000, 27'h7FC0000);
    apply("nan_in",          27'h3FC0001, 27'h1FC0000, 27'h3FE0000);
    apply("negzero_pair",    27'h4000000, 27'h4000000, 27'h4000000);
    apply("mixed_zero",      27'h0000000, 27'h4000000, 27'h0000000);
    apply("denorm_flush",    27'h0000123, 27'h1FC0000, 27'h1FC0000);
    apply("sign_larger",     27'h1FC0000, 27'h5FE0000, 27'h5F80000);
    apply("underflow",       27'h0040001, 27'h4040000, 27'h0000000);
  endtask

  initial begin
    logic [26:0] x, y;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("reset_state", sum, 27'h0);
    end
    rst = 1'b1;
    directed();
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("rst_async", sum, 27'h0);
    expq.delete();
    tagq.delete();
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold", sum, 27'h0);
    end
    rst = 1'b1;
    directed();
    for (int i = 0; i < 3000; i++) begin
      x = rnd_op();
      case ($urandom_range(0, 3))
        0: y = rnd_op();
        1: y = near(x);
        2: y = {~x[26], x[25:0]};
        default: y = near(x);
      endcase
      if ($urandom_range(0, 1) == 1) apply("rand", x, y, ref_add(x, y));
      else                           apply("rand", y, x, ref_add(y, x));
    end
    repeat (3) apply("drain", 27'h0, 27'h0, 27'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
